// File: rtl/dual_port_bank_arbiter_if.sv
// Requester-side bundle for dual_port_bank_arbiter: request/grant handshake and
// read-return signals for both ports A and B.
interface dual_port_bank_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata
    );
endinterface

// File: rtl/dual_port_bank_arbiter.sv
// Shares four single-port RAM banks between two requesters with round-robin on
// same-bank conflicts. Optional conflict counter: define ARB_CONFLICT_CNT_EN.
module dual_port_bank_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dual_port_bank_arbiter_if.slave  port_if,
    output logic [3:0]               bank_ce_o,
    output logic [3:0]               bank_we_o,
    output logic [4*(ADDR_W-2)-1:0]  bank_addr_o,
    output logic [4*DATA_W-1:0]      bank_wdata_o,
    input  logic [4*DATA_W-1:0]      bank_rdata_i
`ifdef ARB_CONFLICT_CNT_EN
    ,
    output logic [CNT_W-1:0]         conflict_cnt_o
`endif
);

    localparam int LA_W = ADDR_W - 2;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    prio_e prio_q, prio_d;

    logic [1:0] a_bank, b_bank;
    logic       conflict;
    logic       a_gnt, b_gnt;

    logic [3:0]              bank_ce_d,    bank_ce_q;
    logic [3:0]              bank_we_d,    bank_we_q;
    logic [4*LA_W-1:0]       bank_addr_d,  bank_addr_q;
    logic [4*DATA_W-1:0]     bank_wdata_d, bank_wdata_q;

    // Read return pipeline: stage 1 tracks the bank strobe cycle, stage 2 the data cycle.
    logic       a_rd1_d, a_rd1_q, a_rvalid_q;
    logic       b_rd1_d, b_rd1_q, b_rvalid_q;
    logic [1:0] a_idx1_q, a_idx2_q;
    logic [1:0] b_idx1_q, b_idx2_q;

    logic [DATA_W-1:0] rd_bank [4];

    assign a_bank   = port_if.a_addr[ADDR_W-1 -: 2];
    assign b_bank   = port_if.b_addr[ADDR_W-1 -: 2];
    assign conflict = port_if.a_req && port_if.b_req && (a_bank == b_bank);

    assign a_gnt = rst_n && port_if.a_req && !(conflict && (prio_q == PRIO_B));
    assign b_gnt = rst_n && port_if.b_req && !(conflict && (prio_q == PRIO_A));

    assign port_if.a_gnt = a_gnt;
    assign port_if.b_gnt = b_gnt;

    // Every conflict transfers exactly one side, so flipping hands the next one to the loser.
    always_comb begin
        prio_d = prio_q;
        if (conflict) begin
            prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        bank_ce_d    = '0;
        bank_we_d    = '0;
        bank_addr_d  = '0;
        bank_wdata_d = '0;
        a_rd1_d      = a_gnt && !port_if.a_we;
        b_rd1_d      = b_gnt && !port_if.b_we;
        for (int k = 0; k < 4; k++) begin
            if (a_gnt && (a_bank == k[1:0])) begin
                bank_ce_d[k]                   = 1'b1;
                bank_we_d[k]                   = port_if.a_we;
                bank_addr_d[k*LA_W +: LA_W]    = port_if.a_addr[LA_W-1:0];
                bank_wdata_d[k*DATA_W +: DATA_W] = port_if.a_wdata;
            end else if (b_gnt && (b_bank == k[1:0])) begin
                bank_ce_d[k]                   = 1'b1;
                bank_we_d[k]                   = port_if.b_we;
                bank_addr_d[k*LA_W +: LA_W]    = port_if.b_addr[LA_W-1:0];
                bank_wdata_d[k*DATA_W +: DATA_W] = port_if.b_wdata;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q       <= PRIO_A;
            bank_ce_q    <= '0;
            bank_we_q    <= '0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
            a_rd1_q      <= 1'b0;
            b_rd1_q      <= 1'b0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_idx1_q     <= '0;
            b_idx1_q     <= '0;
            a_idx2_q     <= '0;
            b_idx2_q     <= '0;
        end else begin
            prio_q       <= prio_d;
            bank_ce_q    <= bank_ce_d;
            bank_we_q    <= bank_we_d;
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
            a_rd1_q      <= a_rd1_d;
            b_rd1_q      <= b_rd1_d;
            a_rvalid_q   <= a_rd1_q;
            b_rvalid_q   <= b_rd1_q;
            a_idx1_q     <= a_bank;
            b_idx1_q     <= b_bank;
            a_idx2_q     <= a_idx1_q;
            b_idx2_q     <= b_idx1_q;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_rd_bank
        assign rd_bank[g] = bank_rdata_i[g*DATA_W +: DATA_W];
    end

    assign bank_ce_o    = bank_ce_q;
    assign bank_we_o    = bank_we_q;
    assign bank_addr_o  = bank_addr_q;
    assign bank_wdata_o = bank_wdata_q;

    assign port_if.a_rvalid = a_rvalid_q;
    assign port_if.b_rvalid = b_rvalid_q;
    assign port_if.a_rdata  = a_rvalid_q ? rd_bank[a_idx2_q] : '0;
    assign port_if.b_rdata  = b_rvalid_q ? rd_bank[b_idx2_q] : '0;

`ifdef ARB_CONFLICT_CNT_EN
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign conflict_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_dual_port_bank_arbiter.sv
// Directed self-checking bench for dual_port_bank_arbiter; bank read data is a
// fixed per-bank pattern so each returned byte identifies its source bank.
module tb_dual_port_bank_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;
    localparam int LA_W   = ADDR_W - 2;

    logic clk;
    logic rst_n;
    logic [3:0]             bank_ce, bank_we;
    logic [4*LA_W-1:0]      bank_addr;
    logic [4*DATA_W-1:0]    bank_wdata;
    logic [4*DATA_W-1:0]    bank_rdata;
`ifdef ARB_CONFLICT_CNT_EN
    logic [CNT_W-1:0]       conflict_cnt;
`endif

    int total;
    int bad;

    logic [7:0] pat [4];
    logic [7:0] b2b_addr [4];

    dual_port_bank_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pif ();

    dual_port_bank_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .port_if      (pif),
        .bank_ce_o    (bank_ce),
        .bank_we_o    (bank_we),
        .bank_addr_o  (bank_addr),
        .bank_wdata_o (bank_wdata),
        .bank_rdata_i (bank_rdata)
`ifdef ARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt_o (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bank_rdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LA_W-1:0] addr_sl(input int i);
        return bank_addr[i*LA_W +: LA_W];
    endfunction

    function automatic logic [DATA_W-1:0] wdata_sl(input int i);
        return bank_wdata[i*DATA_W +: DATA_W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pif.a_req = 1'b0; pif.a_we = 1'b0; pif.a_addr = '0; pif.a_wdata = '0;
        pif.b_req = 1'b0; pif.b_we = 1'b0; pif.b_addr = '0; pif.b_wdata = '0;
    endtask

    task automatic set_a(input logic we, input logic [7:0] addr, input logic [7:0] wd);
        pif.a_req = 1'b1; pif.a_we = we; pif.a_addr = addr; pif.a_wdata = wd;
    endtask

    task automatic set_b(input logic we, input logic [7:0] addr, input logic [7:0] wd);
        pif.b_req = 1'b1; pif.b_we = we; pif.b_addr = addr; pif.b_wdata = wd;
    endtask

    // Both ports must never be granted into the same bank.
    always @(negedge clk) begin
        if (rst_n) begin
            check("same_bank_grant",
                  pif.a_gnt && pif.b_gnt && (pif.a_addr[7:6] == pif.b_addr[7:6]), 1'b0);
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        pat[0] = 8'hA0; pat[1] = 8'hB1; pat[2] = 8'hC2; pat[3] = 8'hD3;
        b2b_addr[0] = 8'h00; b2b_addr[1] = 8'h40; b2b_addr[2] = 8'h80; b2b_addr[3] = 8'hC0;

        // Reset with both requests high.
        rst_n = 1'b0;
        idle();
        set_a(1'b0, 8'h05, 8'h11);
        set_b(1'b1, 8'h83, 8'h5A);
        repeat (2) @(posedge clk);
        #2;
        check("rst_a_gnt",   pif.a_gnt, 1'b0);
        check("rst_b_gnt",   pif.b_gnt, 1'b0);
        check("rst_ce",      bank_ce, 4'b0000);
        check("rst_we",      bank_we, 4'b0000);
        check("rst_addr",    bank_addr, '0);
        check("rst_wdata",   bank_wdata, '0);
        check("rst_a_rv",    pif.a_rvalid, 1'b0);
        check("rst_b_rv",    pif.b_rvalid, 1'b0);
        check("rst_a_rdata", pif.a_rdata, '0);
        check("rst_b_rdata", pif.b_rdata, '0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Parallel access: A read bank0, B write bank2.
        set_a(1'b0, 8'h05, 8'h00);
        set_b(1'b1, 8'h83, 8'h5A);
        #1;
        check("par_a_gnt", pif.a_gnt, 1'b1);
        check("par_b_gnt", pif.b_gnt, 1'b1);
        tick();
        idle();
        #1;
        check("par_ce",     bank_ce, 4'b0101);
        check("par_we",     bank_we, 4'b0100);
        check("par_addr0",  addr_sl(0), 6'h05);
        check("par_addr2",  addr_sl(2), 6'h03);
        check("par_wdata2", wdata_sl(2), 8'h5A);
        check("par_wdata0", wdata_sl(0), 8'h00);
        check("par_addr1",  addr_sl(1), 6'h00);
        check("par_a_rv1",  pif.a_rvalid, 1'b0);
        tick();
        check("par_a_rv2",  pif.a_rvalid, 1'b1);
        check("par_a_rdata", pif.a_rdata, 8'hA0);
        check("par_b_rv2",  pif.b_rvalid, 1'b0);
        check("par_ce_idle", bank_ce, 4'b0000);
        tick();
        check("par_a_rv3",  pif.a_rvalid, 1'b0);

        // Conflict on bank1: both hold reads for four transfers.
        set_a(1'b0, 8'h41, 8'h00);
        set_b(1'b0, 8'h42, 8'h00);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("cf_a_gnt%0d", i), pif.a_gnt, (i % 2) == 0);
            check($sformatf("cf_b_gnt%0d", i), pif.b_gnt, (i % 2) == 1);
            tick();
            check($sformatf("cf_ce%0d", i),    bank_ce, 4'b0010);
            check($sformatf("cf_addr%0d", i),  addr_sl(1), ((i % 2) == 0) ? 6'h01 : 6'h02);
            check($sformatf("cf_a_rv%0d", i),  pif.a_rvalid, (i >= 1) && (((i - 1) % 2) == 0));
            check($sformatf("cf_b_rv%0d", i),  pif.b_rvalid, (i >= 1) && (((i - 1) % 2) == 1));
        end
        idle();
        #1;
        tick();
        check("cf_b_rv_last",  pif.b_rvalid, 1'b1);
        check("cf_b_rdata",    pif.b_rdata, 8'hB1);
        tick();

        // Back-to-back reads across all four banks from port A.
        for (int c = 0; c < 6; c++) begin
            if (c < 4) set_a(1'b0, b2b_addr[c], 8'h00);
            else       idle();
            #1;
            if (c < 4) check($sformatf("b2b_gnt%0d", c), pif.a_gnt, 1'b1);
            check($sformatf("b2b_ce%0d", c), bank_ce,
                  (c >= 1 && c <= 4) ? (4'b0001 << (c - 1)) : 4'b0000);
            check($sformatf("b2b_rv%0d", c), pif.a_rvalid, c >= 2);
            if (c >= 2) check($sformatf("b2b_rdata%0d", c), pif.a_rdata, pat[c-2]);
            tick();
        end
        check("b2b_rv_end", pif.a_rvalid, 1'b0);

        // One conflict on bank3 leaves prio with B.
        set_a(1'b0, 8'hC1, 8'h00);
        set_b(1'b0, 8'hC2, 8'h00);
        #1;
        check("pre_a_gnt", pif.a_gnt, 1'b1);
        check("pre_b_gnt", pif.b_gnt, 1'b0);
        tick();
        idle();
        tick();

        // Reset mid-read: the granted read must never return.
        set_a(1'b0, 8'h10, 8'h00);
        #1;
        check("mid_a_gnt", pif.a_gnt, 1'b1);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        check("mid_ce_clr", bank_ce, 4'b0000);
        check("mid_rv0",    pif.a_rvalid, 1'b0);
        tick();
        check("mid_rv1",    pif.a_rvalid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_rv2",    pif.a_rvalid, 1'b0);
        set_a(1'b0, 8'hC1, 8'h00);
        set_b(1'b0, 8'hC2, 8'h00);
        #1;
        check("post_a_gnt", pif.a_gnt, 1'b1);
        check("post_b_gnt", pif.b_gnt, 1'b0);
        tick();
        check("post_rv",    pif.a_rvalid, 1'b0);
        idle();
        tick();

`ifdef ARB_CONFLICT_CNT_EN
        rst_n = 1'b0;
        #1;
        check("cnt_rst0", conflict_cnt, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_a(1'b0, 8'h81, 8'h00);
        set_b(1'b0, 8'h82, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("cnt%0d", i), conflict_cnt, (i < 3) ? (i + 1) : 3);
        end
        idle();
        tick();
        check("cnt_hold", conflict_cnt, 2'd3);
        rst_n = 1'b0;
        #1;
        check("cnt_rst1", conflict_cnt, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
